// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the default operand width.
package seq_divider_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Counter width able to hold 0..width-1 (never narrower than one bit).
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_control.sv
// Divider sequencer: IDLE/LOAD/ITER/DONE FSM plus the iteration counter,
// producing the datapath strobes and the busy/done status.
module div_control
    import seq_divider_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             dvsr_zero_i,
    input  logic             cnt_last_i,
    output logic             capture_o,
    output logic             load_o,
    output logic             iter_o,
    output logic             result_we_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cnt_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and iteration counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and strobe decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture_o   = 1'b0;
        load_o      = 1'b0;
        iter_o      = 1'b0;
        result_we_o = 1'b0;
        done_o      = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    capture_o = 1'b1;
                    state_d   = ST_LOAD;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_o = 1'b1;
                cnt_d  = '0;
                // A zero divisor skips iteration and writes the dbz result now.
                if (dvsr_zero_i) begin
                    result_we_o = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d     = ST_ITER;
                end
            end
            ST_ITER: begin
                iter_o = 1'b1;
                if (cnt_last_i) begin
                    result_we_o = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d     = ST_ITER;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_o  = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle MSB first, with
// registered quotient/remainder/dbz results.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic             capture_s, load_s, iter_s, result_we_s;
    logic             dvsr_zero_s, cnt_last_s;
    logic [CNT_W-1:0] cnt_s;

    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] shift_q, shift_d;
    // Restored remainder is always below the divisor, so WIDTH bits hold it;
    // the extra (WIDTH+1)th bit only exists in the shifted/trial values.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH:0]   shifted_s, trial_s;
    logic             qbit_s;

    logic [WIDTH-1:0] quo_q, rmd_q;
    logic             dbz_q;

    div_control #(.CNT_W(CNT_W)) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .dvsr_zero_i (dvsr_zero_s),
        .cnt_last_i  (cnt_last_s),
        .capture_o   (capture_s),
        .load_o      (load_s),
        .iter_o      (iter_s),
        .result_we_o (result_we_s),
        .busy_o      (busy),
        .done_o      (done),
        .cnt_o       (cnt_s)
    );

    assign dvsr_zero_s = (dvsr_q == '0);
    assign cnt_last_s  = (cnt_s == CNT_LAST);

    // One restoring step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        shifted_s = {rem_q, shift_q[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvsr_q};
        qbit_s    = ~trial_s[WIDTH];
        if (qbit_s) begin
            rem_d = trial_s[WIDTH-1:0];
        end else begin
            rem_d = shifted_s[WIDTH-1:0];
        end
        shift_d = {shift_q[WIDTH-2:0], qbit_s};
    end

    // Operand capture and iteration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvsr_q  <= '0;
            shift_q <= '0;
            rem_q   <= '0;
        end else begin
            if (capture_s) begin
                dvsr_q  <= divisor;
                shift_q <= dividend;
            end
            if (load_s) begin
                rem_q <= '0;
            end
            if (iter_s) begin
                rem_q   <= rem_d;
                shift_q <= shift_d;
            end
        end
    end

    // Result registers, written only on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rmd_q <= '0;
            dbz_q <= 1'b0;
        end else if (result_we_s) begin
            if (dvsr_zero_s) begin
                quo_q <= '1;
                rmd_q <= shift_q;
                dbz_q <= 1'b1;
            end else begin
                quo_q <= shift_d;
                rmd_q <= rem_d;
                dbz_q <= 1'b0;
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): directed table, corner
// sequences, randomized operations and a back-to-back exhaustive sweep.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, dbz;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } res_t;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division; latency counted in edges from the
    // start-sampling edge to the edge that raises done.
    function automatic res_t model(input int a, input int b);
        res_t m;
        if (b == 0) begin
            m.q = '1; m.r = W'(a); m.z = 1'b1; m.lat = 1;
        end else begin
            m.q = W'(a / b); m.r = W'(a % b); m.z = 1'b0; m.lat = W + 1;
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 60);
    endtask

    // Single operation: start for one edge, then scramble inputs.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez, input int elat, input string tag);
        int n;
        start = 1'b1; dividend = a; divisor = b;
        tick();
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        wait_done(n);
        check({tag, "_latency"}, n, elat);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_dbz"}, dbz, ez);
        check({tag, "_busy_in_done"}, busy, 1'b1);
        tick();
        check({tag, "_done_single"}, done, 1'b0);
        check({tag, "_busy_idle"}, busy, 1'b0);
        check({tag, "_quotient_hold"}, quotient, eq);
        check({tag, "_remainder_hold"}, remainder, er);
    endtask

    initial begin
        vec_t tbl[9];
        res_t m;
        int   n, ndone, gap, elat;
        logic [W-1:0] a, b;

        tbl[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1,  z: 1'b0};
        tbl[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0,  z: 1'b0};
        tbl[2] = '{a: 4'd3,  b: 4'd9,  q: 4'd0,  r: 4'd3,  z: 1'b0};
        tbl[3] = '{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7,  z: 1'b1};
        tbl[4] = '{a: 4'd6,  b: 4'd3,  q: 4'd2,  r: 4'd0,  z: 1'b0};
        tbl[5] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0,  z: 1'b0};
        tbl[6] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0,  z: 1'b0};
        tbl[7] = '{a: 4'd0,  b: 4'd0,  q: 4'd15, r: 4'd0,  z: 1'b1};
        tbl[8] = '{a: 4'd14, b: 4'd5,  q: 4'd2,  r: 4'd4,  z: 1'b0};

        rst = 1'b1; start = 1'b1; dividend = 4'd9; divisor = 4'd2;
        tick();
        tick();
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_quotient", quotient, 4'd0);
        check("reset_remainder", remainder, 4'd0);
        check("reset_dbz", dbz, 1'b0);

        // First edge with rst low must accept start.
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z,
                  (tbl[i].b == 4'd0) ? 1 : W + 1, $sformatf("vec%0d", i));
        end

        // Start pulsed with other operands during ITER is ignored.
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; dividend = 4'd9; divisor = 4'd2;
        tick();
        start = 1'b0;
        wait_done(n);
        check("ignore_start_latency", n + 3, W + 1);
        check("ignore_start_quotient", quotient, 4'd3);
        check("ignore_start_remainder", remainder, 4'd1);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) ndone++;
        end
        check("ignore_start_extra_done", ndone, 0);

        // Reset during the second ITER cycle aborts without a done pulse.
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_quotient", quotient, 4'd0);
        check("abort_remainder", remainder, 4'd0);
        check("abort_dbz", dbz, 1'b0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        do_op(4'd10, 4'd3, 4'd3, 4'd1, 1'b0, W + 1, "after_abort");

        // Randomized operations against the model.
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom);
            b = W'($urandom_range(0, 15));
            m = model(a, b);
            do_op(a, b, m.q, m.r, m.z, m.lat, $sformatf("rand%0d", i));
        end

        // Exhaustive sweep with start held high; operands for the next
        // operation are presented while done is high.
        start = 1'b1; dividend = 4'd0; divisor = 4'd0;
        tick();
        for (int i = 0; i < 256; i++) begin
            a = W'(i >> 4);
            b = W'(i & 15);
            m = model(a, b);
            elat = (i == 0) ? m.lat : m.lat + 2;
            gap = 0;
            do begin
                tick();
                gap++;
            end while (!done && gap < 60);
            if (i < 255) begin
                dividend = W'((i + 1) >> 4);
                divisor  = W'((i + 1) & 15);
            end else begin
                start = 1'b0;
            end
            check($sformatf("sweep_%0d_%0d_period", a, b), gap, elat);
            check($sformatf("sweep_%0d_%0d_q", a, b), quotient, m.q);
            check($sformatf("sweep_%0d_%0d_r", a, b), remainder, m.r);
            check($sformatf("sweep_%0d_%0d_dbz", a, b), dbz, m.z);
        end
        tick();
        check("sweep_final_done_low", done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
